uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmit path, the Transmitter Holding Register (THR), among N_REQ byte-stream requesters (e.g. ESP8266 command sequencer, debug logger). It locks the grant to one requester for a whole packet, delimited by `req_last`, and paces writes to the THR's write-enable/ready handshake. It also releases a stalled requester after a programmable timeout. It sits between the requesters and the THR input.

---
 rtl/uart_tx_arbiter.sv | 158 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART THR among N_REQ byte-stream requesters.
// The grant is held for a whole packet (ended by req_last). A stalled owner is dropped after TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               thr_ready,
  output logic               thr_wr_en,
  output logic [7:0]         thr_data,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               err_timeout,
  output logic [2:0]         err_id,
  output logic [1:0]         dbg_state
);

  // Handshake: a byte moves from requester i when req_valid[i] && req_ready[i] are both high
  // at a rising CLK edge. req_ready is combinational and is high only for the owner in SEND,
  // where it follows thr_ready.
  localparam int IW = $clog2(N_REQ);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW:0] TMO = (CW+1)'(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WRITE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             wr_q, wr_d;
  logic [7:0]       data_q, data_d;
  logic             last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW:0]      cnt_inc;
  logic             err_q, err_d;
  logic [2:0]       err_id_q, err_id_d;

  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    cand;
  logic [7:0]       owner_data;

  // ptr always holds the current or most recent owner, so it doubles as the owner index.
  assign owner_data = req_data[{ptr_q, 3'b000} +: 8];

  // Search starts one past ptr so the previous winner is considered last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % N_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    wr_d      = 1'b0;
    data_d    = data_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    err_id_d  = err_id_q;
    req_ready = '0;
    cnt_inc   = {1'b0, cnt_q} + (CW+1)'(1);
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = SEND;
          ptr_d            = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          cnt_d            = '0;
        end
      end
      SEND: begin
        req_ready[ptr_q] = thr_ready;
        if (req_valid[ptr_q] && thr_ready) begin
          data_d  = owner_data;
          wr_d    = 1'b1;
          last_d  = req_last[ptr_q];
          cnt_d   = '0;
          state_d = WRITE;
        end else if (!req_valid[ptr_q]) begin
          if (TIMEOUT != 0 && cnt_inc == TMO) begin
            state_d  = IDLE;
            grant_d  = '0;
            err_d    = 1'b1;
            err_id_d = 3'(ptr_q);
            cnt_d    = '0;
          end else if (TIMEOUT != 0) begin
            cnt_d = cnt_inc[CW-1:0];
          end
        end else begin
          // Owner is presenting data but the THR is full: the stall run is broken.
          cnt_d = '0;
        end
      end
      WRITE: begin
        if (last_q) begin
          state_d = IDLE;
          grant_d = '0;
        end else begin
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = |grant_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      ptr_q    <= IW'(N_REQ - 1);
      grant_q  <= '0;
      busy_q   <= 1'b0;
      wr_q     <= 1'b0;
      data_q   <= 8'h00;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      err_id_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      wr_q     <= wr_d;
      data_q   <= data_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      err_id_q <= err_id_d;
    end
  end

  assign thr_wr_en   = wr_q;
  assign thr_data    = data_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;
  assign err_id      = err_id_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and random bench for uart_tx_arbiter (N_REQ=4, TIMEOUT=8) with a small THR model
// that drops ready for two cycles after every write.
module tb_uart_tx_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        thr_ready = 1'b1;
  logic        thr_wr_en;
  logic [7:0]  thr_data;
  logic [3:0]  grant;
  logic        busy;
  logic        err_timeout;
  logic [2:0]  err_id;
  logic [1:0]  dbg_state;

  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .thr_ready(thr_ready), .thr_wr_en(thr_wr_en), .thr_data(thr_data),
    .grant(grant), .busy(busy), .err_timeout(err_timeout), .err_id(err_id),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic thr_auto = 1'b1;
  logic thr_rand = 1'b0;
  int   thr_hold = 0;
  logic stress = 1'b0;
  logic in_pkt = 1'b0;
  logic prev_ready = 1'b0;
  logic [1:0] pkt_id = '0;
  logic [1:0] mon_id = '0;
  logic rearm0 = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: move past the edge, update the THR ready model, then let inputs settle.
  task automatic step();
    @(posedge CLK);
    #1;
    if (thr_auto) begin
      if (thr_wr_en) begin
        thr_ready = 1'b0;
        thr_hold  = 1;
      end else if (thr_hold > 0) begin
        thr_ready = 1'b0;
        thr_hold--;
      end else begin
        thr_ready = thr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
    #1;
  endtask

  task automatic reset_dut();
    RST       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST       = 1'b0;
    thr_hold  = 0;
    thr_ready = 1'b1;
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic l);
    req_valid[i]      = 1'b1;
    req_data[8*i +: 8] = d;
    req_last[i]       = l;
  endtask

  // Present a byte and return in the cycle after it was taken (the WRITE cycle).
  task automatic send_byte(input int i, input logic [7:0] d, input logic l);
    int n;
    set_req(i, d, l);
    n = 0;
    while (n < 100) begin
      #1;
      if (req_ready[i]) break;
      step();
      n++;
    end
    check("send_byte_taken", 32'(n < 100), 32'd1);
    step();
  endtask

  // Run until every pending one-byte request has been taken and the arbiter is idle.
  task automatic pump();
    int n;
    logic [3:0] taken;
    n = 0;
    while (n < 200) begin
      #1;
      taken = req_valid & req_ready;
      if (req_valid == 4'b0 && grant == 4'b0 && !thr_wr_en) break;
      step();
      for (int i = 0; i < 4; i++) begin
        if (taken[i]) begin
          if (i == 0 && rearm0) begin
            rearm0 = 1'b0;
            req_data[7:0] = 8'hB0;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      n++;
    end
    check("pump_done", 32'(n < 200), 32'd1);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge CLK) begin
    if (RST) begin
      in_pkt     = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (thr_wr_en) begin
        check("wr_needs_ready", 32'(prev_ready), 32'd1);
        if (stress) begin
          mon_id = thr_data[7:6];
          check("stress_owner", 32'(grant), 32'(4'b0001 << mon_id));
          if (in_pkt) check("stress_interleave", 32'(mon_id), 32'(pkt_id));
          in_pkt = !thr_data[5];
          pkt_id = mon_id;
        end else begin
          check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("thr_data", 32'(thr_data), 32'(exp_q.pop_front()));
        end
      end
      if (err_timeout) in_pkt = 1'b0;
      prev_ready = thr_ready;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_dut();
    check("rst_wr_en", 32'(thr_wr_en), 32'd0);
    check("rst_data", 32'(thr_data), 32'h00);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'({err_timeout, err_id}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // Two-byte packet from requester 0.
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h54);
    set_req(0, 8'h41, 1'b0);
    #1;
    check("t1_idle_grant", 32'(grant), 32'd0);
    step();
    check("t1_grant", 32'(grant), 32'b0001);
    check("t1_busy", 32'(busy), 32'd1);
    send_byte(0, 8'h41, 1'b0);
    check("t1_write1", 32'({thr_wr_en, dbg_state}), 32'({1'b1, 2'd2}));
    send_byte(0, 8'h54, 1'b1);
    req_valid[0] = 1'b0;
    check("t1_write2", 32'(thr_wr_en), 32'd1);
    check("t1_grant_held", 32'(grant), 32'b0001);
    step();
    check("t1_release", 32'({busy, grant}), 32'd0);

    // Four simultaneous one-byte packets after reset: 0,1,2,3.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      set_req(i, 8'hA0 + 8'(i), 1'b1);
      exp_q.push_back(8'hA0 + 8'(i));
    end
    pump();
    // Requester 0 asks again right after its turn: it waits for 1,2,3.
    reset_dut();
    for (int i = 0; i < 4; i++) set_req(i, 8'hA0 + 8'(i), 1'b1);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'hB0);
    rearm0 = 1'b1;
    pump();
    check("t2_rr_drained", 32'(exp_q.size()), 32'd0);

    // THR stalled for 20 cycles while requester 2 owns the path.
    thr_auto  = 1'b0;
    thr_ready = 1'b0;
    exp_q.push_back(8'h5C);
    set_req(2, 8'h5C, 1'b1);
    step();
    check("t3_grant", 32'(grant), 32'b0100);
    for (int k = 0; k < 20; k++) begin
      #1;
      check("t3_stall", 32'({req_ready, thr_wr_en}), 32'd0);
      step();
    end
    thr_ready = 1'b1;
    #1;
    check("t3_ready_rise", 32'(req_ready), 32'b0100);
    step();
    req_valid[2] = 1'b0;
    thr_auto = 1'b1;
    check("t3_write", 32'({thr_wr_en, thr_data}), 32'({1'b1, 8'h5C}));
    step();
    check("t3_release", 32'(grant), 32'd0);

    // Requester 1 stalls mid-packet; requester 3 is waiting.
    reset_dut();
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h33);
    set_req(3, 8'h33, 1'b1);
    send_byte(1, 8'h10, 1'b0);
    req_valid[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("t4_hold", 32'({err_timeout, grant}), 32'({1'b0, 4'b0010}));
    end
    step();
    check("t4_err_pulse", 32'({err_timeout, err_id}), 32'({1'b1, 3'd1}));
    check("t4_grant_off", 32'({busy, grant}), 32'd0);
    step();
    check("t4_err_done", 32'({err_timeout, err_id}), 32'({1'b0, 3'd1}));
    check("t4_next_owner", 32'(grant), 32'b1000);
    pump();

    // Reset while in WRITE of requester 2.
    send_byte(2, 8'h77, 1'b0);
    check("t5_in_write", 32'({thr_wr_en, thr_data}), 32'({1'b1, 8'h77}));
    for (int i = 0; i < 4; i++) set_req(i, 8'hC0 + 8'(i), 1'b1);
    RST = 1'b1;
    #1;
    check("t5_rst_wr", 32'({thr_wr_en, thr_data}), 32'd0);
    check("t5_rst_grant", 32'({busy, grant, req_ready}), 32'd0);
    check("t5_rst_err", 32'({err_timeout, err_id}), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST       = 1'b0;
    thr_hold  = 0;
    thr_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hC0 + 8'(i));
    pump();
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // Random stress: packet integrity and write pacing checked by the monitor.
    stress   = 1'b1;
    thr_rand = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 4; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_last[i]  = ($urandom_range(0, 2) == 0);
        req_data[8*i +: 8] = {2'(i), req_last[i], 5'($urandom_range(0, 31))};
      end
      step();
    end
    req_valid = '0;
    thr_rand  = 1'b0;
    repeat (20) step();
    check("stress_idle", 32'(grant), 32'd0);
    stress = 1'b0;

    check("final_exp_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
